// File: rtl/inst_sram_master_pkg.sv
// Shared constants and sizing helpers for the instruction-fetch SRAM master.
package inst_sram_master_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1C000000;
    localparam logic [1:0]  SIZE_WORD        = 2'd2;

    // Counters must hold the value DEPTH itself, hence one extra bit.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; simultaneous push and pop is allowed when full.
module fetch_fifo
    import inst_sram_master_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(DEPTH));
    assign count    = cnt;
    assign pop_data = mem[rd_ptr];
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/inst_sram_master.sv
// Instruction fetch master: issues sequential SRAM-like reads, tags them with
// their PC and queues returned words for decode; redirects flush and discard.
module inst_sram_master
    import inst_sram_master_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_data,
    output logic        req,
    output logic        wr,
    output logic [1:0]  size,
    output logic [3:0]  wstrb,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic        addr_ok,
    input  logic        data_ok,
    input  logic [31:0] rdata
);

    localparam int unsigned CW = cnt_width(DEPTH);

    logic          req_r;
    logic          req_next;
    logic [31:0]   fetch_pc;
    logic          stale_r;
    logic [31:0]   stale_addr;
    logic [CW-1:0] discard_cnt;
    logic [CW-1:0] discard_next;

    logic          acc;
    logic          rsp;
    logic          discarding;
    logic          out_push;
    logic          inst_pop;

    logic          tag_full;
    logic          tag_empty;
    logic [CW-1:0] tag_count;
    logic [31:0]   tag_head;
    logic          out_full;
    logic          out_empty;
    logic [CW-1:0] out_count;
    logic [63:0]   out_head;

    logic [CW:0]   outst_next;
    logic [CW:0]   fifo_next;
    logic [CW:0]   occ_next;

    assign wr    = 1'b0;
    assign size  = SIZE_WORD;
    assign wstrb = '0;
    assign wdata = '0;

    // A request raised before a redirect keeps its old address until accepted.
    assign req  = req_r & ~reset;
    assign addr = reset ? RESET_PC : (stale_r ? stale_addr : fetch_pc);

    assign acc        = req & addr_ok;
    assign rsp        = data_ok & ~tag_empty & ~reset;
    assign discarding = (discard_cnt != '0);
    assign out_push   = rsp & ~discarding & ~redirect_valid & (~out_full | inst_pop);

    assign inst_valid = ~out_empty & ~reset;
    assign inst_pop   = inst_valid & inst_ready;
    assign inst_pc    = out_head[63:32];
    assign inst_data  = out_head[31:0];

    always_comb begin
        outst_next = {1'b0, tag_count} + (CW+1)'(acc) - (CW+1)'(rsp);
        fifo_next  = redirect_valid ? '0
                   : {1'b0, out_count} + (CW+1)'(out_push) - (CW+1)'(inst_pop);
        occ_next   = outst_next + fifo_next;

        req_next = (req & ~addr_ok)
                 | ((occ_next < (CW+1)'(DEPTH)) & (~tag_full | rsp));

        // Redirect snapshots everything in flight; a stale request joins on acceptance.
        if (redirect_valid)
            discard_next = outst_next[CW-1:0];
        else
            discard_next = discard_cnt - CW'(rsp & discarding) + CW'(acc & stale_r);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_r       <= 1'b1;
            fetch_pc    <= RESET_PC;
            stale_r     <= 1'b0;
            stale_addr  <= RESET_PC;
            discard_cnt <= '0;
        end else begin
            req_r       <= req_next;
            discard_cnt <= discard_next;

            if (redirect_valid)
                fetch_pc <= {redirect_pc[31:2], 2'b00};
            else if (acc && !stale_r)
                fetch_pc <= fetch_pc + 32'd4;

            if (redirect_valid && req && !addr_ok) begin
                stale_r <= 1'b1;
                if (!stale_r) stale_addr <= fetch_pc;
            end else if (acc) begin
                stale_r <= 1'b0;
            end
        end
    end

    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (1'b0),
        .push      (acc),
        .push_data (addr),
        .pop       (rsp),
        .pop_data  (tag_head),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (tag_count)
    );

    fetch_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (out_push),
        .push_data ({tag_head, rdata}),
        .pop       (inst_pop),
        .pop_data  (out_head),
        .full      (out_full),
        .empty     (out_empty),
        .count     (out_count)
    );

endmodule

// File: tb/tb_inst_sram_master.sv
// Randomized bench for inst_sram_master with a transaction-level fetch model.
module tb_inst_sram_master;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h1C000000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok = 1'b0;
    logic        data_ok = 1'b0;
    logic [31:0] rdata = '0;

    inst_sram_master #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_pc        (inst_pc),
        .inst_data      (inst_data),
        .req            (req),
        .wr             (wr),
        .size           (size),
        .wstrb          (wstrb),
        .addr           (addr),
        .wdata          (wdata),
        .addr_ok        (addr_ok),
        .data_ok        (data_ok),
        .rdata          (rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic        doomed;
    } ent_t;

    ent_t        rq[$];        // responder: accepted, not yet returned
    logic [63:0] exp_q[$];     // expected {pc, word} visible to decode
    logic [31:0] post_pcs[$];  // PCs delivered since the last redirect

    int total = 0;
    int bad   = 0;
    int n_acc = 0;
    int n_deliv = 0;

    int p_aok = 100, p_dok = 100, p_rdy = 100, p_redir = 0, p_spur = 0;
    bit          force_redir = 0;
    logic [31:0] force_tgt = '0;
    logic        rst_in = 1'b1;

    logic [31:0] exp_addr = RESET_PC;
    logic [31:0] held_addr = '0;
    bit          prev_pending = 0;
    bit          pend_doomed = 0;
    bit          first_cyc = 0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A0F0F;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
        end
    endtask

    task automatic model();
        logic        acc;
        bit          live;
        ent_t        e;
        live = 0;
        e    = '0;
        if (reset) begin
            check("rst_req", req, 0);
            check("rst_valid", inst_valid, 0);
            check("rst_addr", addr, RESET_PC);
            rq.delete();
            exp_q.delete();
            post_pcs.delete();
            pend_doomed  = 0;
            prev_pending = 0;
            exp_addr     = RESET_PC;
            first_cyc    = 1;
            return;
        end
        if (first_cyc) begin
            check("post_rst_req", req, 1);
            check("post_rst_addr", addr, RESET_PC);
            check("const_outs", {wr, size, wstrb, wdata}, {1'b0, 2'd2, 4'h0, 32'h0});
            first_cyc = 0;
        end
        if (prev_pending) begin
            check("hold_req", req, 1);
            check("hold_addr", addr, held_addr);
        end
        acc = req && addr_ok;
        if (data_ok && rq.size() > 0) begin
            e    = rq.pop_front();
            live = !e.doomed && !redirect_valid;
        end
        if (acc) begin
            if (pend_doomed) begin
                rq.push_back('{a: addr, doomed: 1'b1});
                pend_doomed = 0;
            end else begin
                check("req_addr", addr, exp_addr);
                exp_addr += 32'd4;
                rq.push_back('{a: addr, doomed: 1'b0});
            end
            n_acc++;
        end
        check("valid", inst_valid, exp_q.size() != 0);
        if (inst_valid && exp_q.size() != 0)
            check("inst", {inst_pc, inst_data}, exp_q[0]);
        if (!redirect_valid && inst_valid && inst_ready && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            n_deliv++;
            if (post_pcs.size() < 4) post_pcs.push_back(inst_pc);
        end
        if (redirect_valid) begin
            exp_q.delete();
            foreach (rq[i]) rq[i].doomed = 1'b1;
            if (req && !addr_ok) pend_doomed = 1;
            exp_addr = {redirect_pc[31:2], 2'b00};
            post_pcs.delete();
        end
        if (live) exp_q.push_back({e.a, word_at(e.a)});
        prev_pending = req && !addr_ok;
        held_addr    = addr;
        check("cap", (rq.size() + exp_q.size()) <= DEPTH, 1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        reset      = rst_in;
        addr_ok    = ($urandom_range(99) < p_aok);
        inst_ready = ($urandom_range(99) < p_rdy);
        if (rq.size() > 0 && !rst_in) begin
            data_ok = ($urandom_range(99) < p_dok);
            rdata   = word_at(rq[0].a);
        end else begin
            data_ok = !rst_in && ($urandom_range(99) < p_spur);
            rdata   = $urandom;
        end
        if (force_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = force_tgt;
            force_redir    = 0;
        end else begin
            redirect_valid = !rst_in && ($urandom_range(99) < p_redir);
            redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFFFFFC | 32'($urandom_range(3)))
                                                      : $urandom;
        end
        #1;
        model();
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        step();
        step();
        rst_in = 1'b0;
    endtask

    function automatic logic [63:0] post_at(input int unsigned i);
        if (post_pcs.size() > i) return {32'h0, post_pcs[i]};
        return 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    initial begin
        int a0;
        int d0;

        // Streaming throughput
        p_aok = 100; p_dok = 100; p_rdy = 100; p_redir = 0; p_spur = 0;
        do_reset();
        a0 = n_acc; d0 = n_deliv;
        repeat (20) step();
        check("thru_acc", n_acc - a0, 20);
        check("thru_deliv", n_deliv - d0, 18);

        // Decode back-pressure
        do_reset();
        p_rdy = 0;
        a0 = n_acc;
        repeat (12) step();
        check("bp_acc", n_acc - a0, 4);
        check("bp_req_low", req, 0);
        check("bp_valid", inst_valid, 1);
        p_rdy = 100;
        d0 = n_deliv;
        repeat (12) step();
        check("bp_resume", (n_acc - a0) > 4, 1);
        check("bp_drain", (n_deliv - d0) >= 4, 1);

        // Redirect with requests outstanding
        do_reset();
        p_dok = 0;
        step();
        step();
        force_redir = 1; force_tgt = 32'h1C000103;
        step();
        p_dok = 100;
        repeat (15) step();
        check("redir_pc0", post_at(0), 64'h1C000100);
        check("redir_pc1", post_at(1), 64'h1C000104);

        // addr_ok withheld across a redirect
        do_reset();
        repeat (4) step();
        p_aok = 0;
        step();
        force_redir = 1; force_tgt = 32'h1C000200;
        step();
        step();
        p_aok = 100;
        repeat (12) step();
        check("stale_pc0", post_at(0), 64'h1C000200);

        // data_ok coincident with redirect, then spurious data_ok
        repeat (3) step();
        force_redir = 1; force_tgt = 32'h1C000300;
        step();
        p_aok = 0; p_spur = 100;
        repeat (6) step();
        p_aok = 100; p_spur = 0;
        repeat (10) step();
        check("spur_pc0", post_at(0), 64'h1C000300);

        // Address wrap
        force_redir = 1; force_tgt = 32'hFFFFFFFE;
        step();
        repeat (10) step();
        check("wrap_pc0", post_at(0), 64'hFFFFFFFC);
        check("wrap_pc1", post_at(1), 64'h00000000);

        // Randomized traffic
        d0 = n_deliv;
        for (int unsigned blk = 0; blk < 15; blk++) begin
            p_aok   = int'($urandom_range(100, 30));
            p_dok   = int'($urandom_range(100, 30));
            p_rdy   = int'($urandom_range(100, 20));
            p_redir = int'($urandom_range(8, 0));
            p_spur  = int'($urandom_range(20, 0));
            if ($urandom_range(3) == 0) do_reset();
            repeat (200) step();
        end
        check("rand_progress", (n_deliv - d0) > 100, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_sram_master.md
INST_SRAM_MASTER -- requirements
Module: inst_sram_master

Interface
REQ-001 The block SHALL expose parameter RESET_PC, default 32'h1C000000, meaning the first fetch address after reset.
REQ-002 The block SHALL expose parameter DEPTH, default 4, meaning the combined cap on outstanding requests plus queued instructions (power of two, 2..8).
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 redirect_valid  in  1  flush pipeline and restart fetch at redirect_pc.
REQ-006 redirect_pc  in  32  new fetch address; bits [1:0] ignored and treated as 0.
REQ-007 inst_valid  out  1 / inst_ready  in  1  valid/ready handshake to decode; transfer when both are high.
REQ-008 inst_pc  out  32 / inst_data  out  32  PC and instruction word of the head entry.
REQ-009 req  out  1 / wr  out  1 / size  out  2 / wstrb  out  4 / addr  out  32 / wdata  out  32  SRAM-like master request; wr=0, size=2'd2, wstrb=4'h0, wdata=0 constant.
REQ-010 addr_ok  in  1 / data_ok  in  1 / rdata  in  32  SRAM-like responder acceptance, in-order read return and read data.

Function
REQ-011 A request SHALL be accepted in a cycle where req && addr_ok; a response is consumed in any cycle data_ok=1; both may occur in the same cycle.
REQ-012 Once raised, req SHALL stay high with addr unchanged until addr_ok, regardless of redirect_valid.
REQ-013 A new request SHALL be raised only when outstanding + fifo_count < DEPTH, with both counts evaluated after this cycle's events; data_ok is never back-pressured.
REQ-014 addr SHALL equal fetch_pc, which advances by 4 on each acceptance and wraps from 32'hFFFFFFFC to 0.
REQ-015 Every accepted address SHALL be pushed into a tag queue of DEPTH entries and popped on data_ok; the popped address becomes the instruction's PC.
REQ-016 On a non-discarded data_ok, {tag, rdata} SHALL enter the output FIFO; inst_valid rises the following cycle (1-cycle registered latency).
REQ-017 The output FIFO SHALL be first-in-first-out, DEPTH deep, and SHALL support push and pop in the same cycle when full or when empty-with-bypass-disabled.
REQ-018 On redirect_valid, fetch_pc SHALL load {redirect_pc[31:2],2'b00} and the output FIFO SHALL empty, including any entry handshaken that cycle.
REQ-019 On redirect_valid, discard_cnt SHALL be set to the outstanding count, including a request accepted that cycle and excluding a response consumed that cycle.
REQ-020 A request still pending at redirect (req high, not yet accepted) SHALL complete per REQ-012 and SHALL be counted into discard_cnt when accepted.
REQ-021 While discard_cnt > 0, each data_ok SHALL decrement discard_cnt, pop the tag and drop the data; no inst_valid results.
REQ-022 A data_ok in the same cycle as redirect_valid SHALL be dropped.
REQ-023 The first post-redirect request SHALL be raised no earlier than the cycle after redirect_valid.
REQ-024 Back-to-back redirects SHALL each re-apply REQ-018..REQ-020; the last one wins fetch_pc.
REQ-025 data_ok with zero outstanding SHALL be ignored and SHALL leave all state unchanged.
REQ-026 Sustained throughput SHALL be one instruction per cycle against a responder with 1-cycle data return while inst_ready=1.

Reset
REQ-027 While reset=1: req=0, inst_valid=0, fetch_pc=RESET_PC, outstanding=0, discard_cnt=0, both queues empty, addr=RESET_PC.
REQ-028 req SHALL rise with addr=RESET_PC in the first cycle after reset deasserts.
REQ-029 Reset mid-transaction SHALL abandon all in-flight state; the responder is reset by the same reset.

Structure
REQ-030 RESET_PC default, SIZE_WORD=2'd2 and the outstanding/discard counter width ($clog2(DEPTH)+1) SHALL live in a shared package.
REQ-031 A parameterised synchronous FIFO sub-module fetch_fifo (WIDTH, DEPTH; push/pop/flush/full/empty/count) SHALL be instantiated twice: tag queue (32 bits) and output FIFO (64 bits).

Verification
REQ-032 Reset release, responder with zero-wait addr_ok and 1-cycle data, inst_ready=1 -> addr 1C000000, 1C000004, 1C000008 issued on consecutive cycles; inst_pc follows in order, one per cycle.
REQ-033 inst_ready=0 held -> exactly DEPTH=4 requests accepted, req stays low, FIFO holds 4 entries; ready=1 -> drains in order, issue resumes.
REQ-034 Redirect to 32'h1C000103 with 2 requests outstanding -> both responses dropped; next req addr=1C000100; first inst_pc=1C000100.
REQ-035 addr_ok withheld 3 cycles while redirect pulses -> addr stays stable until accepted; that response is discarded; next addr=redirect target.
REQ-036 data_ok and redirect_valid same cycle; spurious data_ok with nothing outstanding -> the data is dropped, discard_cnt is correct, and no inst_valid results.
REQ-037 Redirect to 32'hFFFFFFFC -> fetch addresses FFFFFFFC then 00000000.
